hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair of the MIPS datapath.
- The ALU's combinational hi/lo outputs are bypassed for mult/div. This block accepts operands and an opcode, computes over multiple cycles, and writes HI/LO.
- mfhi/mflo read `hi`/`lo` directly. mthi/mtlo write them through dedicated strobes.
- The control unit stalls on `busy`.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk      input   1      system clock, rising edge
- rst_n    input   1      asynchronous active-low reset
- start    input   1      one-cycle request; sampled only in IDLE
- op       input   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a        input   WIDTH  rs operand (multiplicand / dividend)
- b        input   WIDTH  rt operand (multiplier / divisor)
- mthi     input   1      write `wdata` to HI; honoured only when not busy
- mtlo     input   1      write `wdata` to LO; honoured only when not busy
- wdata    input   WIDTH  data for mthi/mtlo
- hi       output  WIDTH  HI register
- lo       output  WIDTH  LO register
- busy     output  1      operation in flight
- done     output  1      one-cycle pulse when HI/LO are updated by an operation
- div_zero output  1      sticky flag for the last division: set if divisor was 0, cleared by the next start

Behaviour:
- Reset (async, rst_n=0):
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - State=IDLE, counter=0, internal accumulators=0.
  - Any operation in flight is discarded.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - mthi/mtlo write on the clock edge; both may be asserted together.
  - On start: latch op, |a| and |b|, and the sign bits.
    - Signed ops (MULT, DIV) take two's-complement magnitudes.
    - Unsigned ops take a and b raw.
  - On start: busy=1 from the next cycle, counter=0, div_zero <= (op[1] && b==0), go to CALC.
  - start together with mthi/mtlo in the same cycle: the writes take effect and start is accepted. The result later overwrites HI/LO.
- CALC, 32 cycles, counter 0..31:
  - Multiply: shift-add radix-2 on a 64-bit {hi_acc, lo_acc} accumulator, one multiplier bit per cycle (LSB first).
  - Divide: restoring radix-2, one quotient bit per cycle (MSB first). The remainder is WIDTH+1 bits wide.
  - Leave for FIX when counter==31.
- FIX, 1 cycle:
  - MULT: negate the 64-bit product if sign_a^sign_b.
  - DIV: negate the quotient if sign_a^sign_b; the remainder takes the sign of the dividend.
  - Write hi/lo on the exiting edge.
    - Multiply: hi=product[63:32], lo=product[31:0].
    - Divide: lo=quotient, hi=remainder.
  - On the same edge: done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency:
  - start sampled at edge E0.
  - busy high in the cycles after E0 through E33.
  - hi/lo and done updated at E33, so 33 cycles.
  - A new start is accepted in the cycle that done is high.
- Divide by zero:
  - Runs the full latency. Result: lo=32'hFFFFFFFF, hi=a (the original, unmodified dividend, for both DIV and DIVU).
  - div_zero=1.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- Ignored while busy:
  - start.
  - mthi/mtlo, which are dropped, not queued.
  - Operand changes; a, b and op are not re-sampled.
- hi/lo hold their values throughout CALC and FIX. The old value stays readable until E33.
- Reset asserted mid-CALC/FIX: immediately IDLE, busy=0, hi=lo=0, no done pulse.

Test Plan:
- MULT a=20, b=5 -> at +33 cycles hi=0x00000000, lo=0x00000064, done pulses once, busy high exactly 33 cycles.
- MULT a=-20, b=1, then MULTU a=b=0xFFFFFFFF:
  - MULT -> hi=0xFFFFFFFF, lo=0xFFFFFFEC.
  - MULTU -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-20, b=3 -> lo=0xFFFFFFFA, hi=0xFFFFFFFE. DIVU a=20, b=5 -> lo=4, hi=0.
- DIV a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div_zero=1. Next DIVU 9/2 -> div_zero=0, lo=4, hi=1.
- mthi=0xDEADBEEF while idle -> hi updates next edge. mtlo and start pulses during busy -> ignored; the result matches the first operation only.
- Start MULT, then pull rst_n low at cycle 15 -> hi=lo=0, busy=0, no done. After release, a new MULT 3*4 completes with lo=12.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Shift-add multiply (LSB first) and restoring divide (MSB first), one bit per cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b, quo;
  logic [WIDTH:0]     rem;
  logic [2*WIDTH-1:0] acc;

  logic               in_neg_a, in_neg_b;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, orig_a;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == CNT_W'(WIDTH-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_neg_a  = ~op[0] & a[WIDTH-1];
    in_neg_b  = ~op[0] & b[WIDTH-1];
    in_mag_a  = in_neg_a ? -a : a;
    in_mag_b  = in_neg_b ? -b : b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mag_b[0] ? mag_a : '0)};
    // rem[WIDTH] is always zero between steps; it still feeds the trial subtraction
    div_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    div_diff  = {rem, quo[WIDTH-1]} - {2'b00, mag_b};
    div_ok    = ~div_diff[WIDTH+1];
    prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix   = (sign_a ^ sign_b) ? -quo : quo;
    rem_fix   = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    orig_a    = sign_a ? -mag_a : mag_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      quo      <= '0;
      rem      <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            is_div   <= op[1];
            sign_a   <= in_neg_a;
            sign_b   <= in_neg_b;
            mag_a    <= in_mag_a;
            mag_b    <= in_mag_b;
            quo      <= in_mag_a;
            rem      <= '0;
            acc      <= '0;
            cnt      <= '0;
            div_zero <= op[1] && (b == '0);
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            rem <= div_ok ? div_diff[WIDTH:0] : div_shift;
            quo <= {quo[WIDTH-2:0], div_ok};
          end else begin
            acc   <= {mul_sum, acc[WIDTH-1:1]};
            mag_b <= mag_b >> 1;
          end
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= orig_a;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: fixed vectors, corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] h0, l0;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sp, sq, sr;
    logic [63:0] ux, uy, up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'd0: begin sp = sx * sy; model = {1'b0, sp}; end
      2'd1: begin up = ux * uy; model = {1'b0, up}; end
      default: begin
        if (y == 32'h0) model = {1'b1, x, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          sq = sx / sy;
          sr = sx % sy;
          model = {1'b0, sr[31:0], sq[31:0]};
        end else begin
          up = ux / uy;
          model = {1'b0, 32'(ux % uy), up[31:0]};
        end
      end
    endcase
  endfunction

  // Issue one op from the current (post-edge) point and wait for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit disturb, input string tag);
    int unsigned k, bc;
    bit held;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    h0 = hi; l0 = lo; held = 1'b1; bc = 0; k = 0;
    while (!done && k < 40) begin
      bc += 32'(busy);
      if (hi !== h0 || lo !== l0) held = 1'b0;
      if (disturb && k == 5) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
      end
      if (disturb && k == 6) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    check({tag, " latency"}, k, 33);
    check({tag, " busy_cycles"}, bc, 33);
    check({tag, " hold"}, 32'(held), 1);
    check({tag, " busy_after"}, 32'(busy), 0);
  endtask

  task automatic run_checked(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] eh, input logic [31:0] el, input logic edz,
                             input bit disturb, input string tag);
    run_op(o, x, y, disturb, tag);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " div_zero"}, 32'(div_zero), 32'(edz));
  endtask

  initial begin
    logic [64:0] m;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int unsigned dcount;

    vecs[0]  = '{2'd0, 32'd20,         32'd5,          32'h0000_0000, 32'h0000_0064, 1'b0};
    vecs[1]  = '{2'd0, 32'hFFFF_FFEC,  32'd1,          32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0};
    vecs[2]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[3]  = '{2'd2, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE, 32'hFFFF_FFFA, 1'b0};
    vecs[4]  = '{2'd3, 32'd20,         32'd5,          32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[5]  = '{2'd2, 32'd7,          32'd0,          32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{2'd3, 32'd9,          32'd2,          32'h0000_0001, 32'h0000_0004, 1'b0};
    vecs[7]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[8]  = '{2'd3, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'd2, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{2'd0, 32'h7FFF_FFFF,  32'h8000_0000,  32'hC000_0000, 32'h8000_0000, 1'b0};
    vecs[11] = '{2'd2, 32'd100,        32'hFFFF_FFF9,  32'h0000_0002, 32'hFFFF_FFF2, 1'b0};

    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset div_zero", 32'(div_zero), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: each op starts in the done cycle of the previous one.
    for (int i = 0; i < 12; i++)
      run_checked(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
                  1'b0, $sformatf("vec%0d", i));

    @(posedge clk); #1;
    check("done single pulse", 32'(done), 0);

    mthi = 1'b1; wdata = 32'hDEAD_BEEF; h0 = lo;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi hi", hi, 32'hDEAD_BEEF);
    check("mthi lo untouched", lo, h0);
    mtlo = 1'b1; wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo lo", lo, 32'h0BAD_F00D);
    check("mtlo hi untouched", hi, 32'hDEAD_BEEF);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi+mtlo hi", hi, 32'h1111_2222);
    check("mthi+mtlo lo", lo, 32'h1111_2222);

    run_checked(2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1, "disturbed");

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    run_checked(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, "start+mt");
    check("start+mt early hi", h0, 32'hCAFE_F00D);
    check("start+mt early lo", l0, 32'hCAFE_F00D);

    // Reset in the middle of CALC drops the operation.
    @(posedge clk); #1;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 0);
    check("midreset hi", hi, 0);
    check("midreset lo", lo, 0);
    check("midreset done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      dcount += 32'(done) + 32'(busy);
    end
    check("midreset no done/busy", dcount, 0);
    run_checked(2'd0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, "post-reset");

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (i % 10 == 3) ra = 32'h8000_0000;
      m = model(ro, ra, rb);
      run_checked(ro, ra, rb, m[63:32], m[31:0], m[64], 1'b0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
